pc_stack_unit: RTL and testbench
================================

# pc_stack_unit

Parametrised program-counter unit for the 16-bit CPU. It replaces the fixed increment/absolute-jump counter and adds a conditional signed-relative branch, subroutine call/return through an internal return-address stack, and overflow/underflow error reporting. It sits between the control unit, which drives `en_pc`, `pc_ctrl`, `cond` and `offset_addr`, and the instruction-memory address port, which is fed by `pc_out`.

## Interface
Parameters:
- `ADDR_W`, 16: PC width in bits.
- `OFFS_W`, 8: width of `offset_addr`; must satisfy `OFFS_W <= ADDR_W`.
- `STACK_DEPTH`, 4: number of return-address entries; must be a power of two, >= 2.
- `RESET_VEC`, 1: value loaded into `pc_out` on reset.

Ports:
- `clk`, input, 1: clock; all state updates on posedge.
- `rst`, input, 1: reset, asynchronous, active-low.
- `en_pc`, input, 1: update enable; when 0, PC and stack hold.
- `pc_ctrl`, input, 3: operation select (see Operation).
- `offset_addr`, input, OFFS_W: absolute target (zero-extended) or relative offset (sign-extended).
- `cond`, input, 1: branch condition for relative branch.
- `err_clr`, input, 1: clears `stk_err`; acts independently of `en_pc`.
- `pc_out`, output, ADDR_W: current program counter (registered).
- `sp_level`, output, clog2(STACK_DEPTH)+1: number of valid stack entries.
- `stk_full`, output, 1: high when `sp_level == STACK_DEPTH`.
- `stk_empty`, output, 1: high when `sp_level == 0`.
- `stk_err`, output, 1: sticky overflow/underflow flag.

## Operation
- Reset (`rst = 0`, async): `pc_out = RESET_VEC`, `sp_level = 0`, `stk_err = 0`. Stack contents are don't-care. `stk_empty = 1`, `stk_full = 0`.
- With `en_pc = 1`, `pc_ctrl` selects:
  - `000` hold.
  - `001` INC: `pc <= pc + 1`.
  - `010` JMP: `pc <= zero_ext(offset_addr)`.
  - `011` BR: if `cond`, `pc <= pc + sign_ext(offset_addr)`; else `pc <= pc + 1`.
  - `100` CALL: push `pc + 1`, then `pc <= zero_ext(offset_addr)`.
  - `101` RET: `pc <=` top of stack, then pop.
  - `110`, `111` hold (reserved).
- Arithmetic is modulo 2^ADDR_W. `0xFFFF + 1 = 0x0000`; branches wrap in both directions.
- The stack is LIFO. Push writes entry `[sp_level]` then increments `sp_level`. Pop reads entry `[sp_level-1]` then decrements `sp_level`.
- CALL while `stk_full`: the jump still occurs, the push is discarded, `sp_level` is unchanged, and `stk_err` is set.
- RET while `stk_empty`: `pc <= pc + 1`, `sp_level` stays 0, and `stk_err` is set.
- `stk_err` stays set until a cycle with `err_clr = 1`. If a new error and `err_clr` occur in the same cycle, the set wins.
- With `en_pc = 0`: `pc_out`, `sp_level` and the stack are unchanged regardless of `pc_ctrl`. No errors can be raised.

## Timing
- Every operation completes in one cycle. The new `pc_out` is visible after the posedge that samples the command.
- Back-to-back CALL/RET on consecutive cycles is fully supported. A RET immediately after a CALL returns the just-pushed `pc + 1`.
- `stk_full`, `stk_empty` and `sp_level` reflect the registered pointer. They change on the same edge as `pc_out`.
- When `rst` is asserted mid-sequence, outputs go to their reset values immediately and asynchronously. After `rst` is released, the first posedge executes the command present on that edge.
- Inputs must be stable around the posedge. The block has no combinational path from inputs to outputs.

## Test plan
- Reset and increment: assert `rst = 0`, then release and run INC ×3 → `pc_out` reads 1, then 2, 3, 4; `stk_empty = 1`. Hold `pc = 0xFFFF` and INC → `0x0000`.
- Jump and branch: JMP with `offset_addr = 0x80` → `0x0080`. BR with `0xFE` and `cond = 1` → `0x007E`. BR with `cond = 0` → `0x007F`. BR with `0x7F` at `pc = 0xFFF0` → `0x006F`.
- Nested calls: at `pc = 0x10`, CALL `0x20`, then CALL `0x30` → `sp_level = 2`. RET → `0x21`. RET → `0x11`, with `stk_empty = 1` and `stk_err = 0`.
- Overflow and underflow: 5 CALLs with depth 4 → `stk_full = 1`, `stk_err = 1`, `pc` equals the 5th target, `sp_level = 4`. Then 4 RETs, err_clr, and a RET on empty → `pc + 1`, `stk_err = 1`.
- Enable and clear: `en_pc = 0` with CALL held for 3 cycles → no change to `pc` or `sp_level`. `err_clr = 1` concurrent with an underflow RET → `stk_err` remains 1.
- Async reset mid-stack: with `sp_level = 3`, pulse `rst` low between edges → `pc_out = 1` and `sp_level = 0` immediately. After release, a RET → `pc = 2` and `stk_err = 1`.

Source files
------------

// File: rtl/pc_stack_unit.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// pc_stack_unit
//
// Program-counter unit for the 16-bit CPU. Supports increment, absolute jump,
// conditional signed-relative branch, and subroutine call/return through an
// internal LIFO return-address stack. Stack overflow and underflow are
// reported through a sticky error flag.
//
// Parameters:
//   ADDR_W      PC width in bits
//   OFFS_W      width of offset_addr (OFFS_W <= ADDR_W)
//   STACK_DEPTH number of return-address entries (power of two, >= 2)
//   RESET_VEC   value loaded into pc_out on reset
//
// Ports:
//   clk          clock, all state updates on posedge
//   rst          asynchronous active-low reset
//   en_pc        update enable; when low, PC and stack hold
//   pc_ctrl      operation select (hold/INC/JMP/BR/CALL/RET/reserved)
//   offset_addr  absolute target (zero-extended) or relative offset (sign-extended)
//   cond         branch condition for BR
//   err_clr      clears stk_err, independent of en_pc
//   pc_out       registered program counter
//   sp_level     number of valid stack entries
//   stk_full     sp_level == STACK_DEPTH
//   stk_empty    sp_level == 0
//   stk_err      sticky overflow/underflow flag
// -----------------------------------------------------------------------------
module pc_stack_unit #(
    parameter int                ADDR_W      = 16,
    parameter int                OFFS_W      = 8,
    parameter int                STACK_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_VEC   = ADDR_W'(1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en_pc,
    input  logic [2:0]                   pc_ctrl,
    input  logic [OFFS_W-1:0]            offset_addr,
    input  logic                         cond,
    input  logic                         err_clr,
    output logic [ADDR_W-1:0]            pc_out,
    output logic [$clog2(STACK_DEPTH):0] sp_level,
    output logic                         stk_full,
    output logic                         stk_empty,
    output logic                         stk_err
);

    localparam int PTR_W = $clog2(STACK_DEPTH);
    localparam int SP_W  = PTR_W + 1;

    localparam logic [SP_W-1:0] SP_FULL  = SP_W'(STACK_DEPTH);
    localparam logic [SP_W-1:0] SP_EMPTY = '0;

    typedef enum logic [2:0] {
        OP_HOLD = 3'b000,
        OP_INC  = 3'b001,
        OP_JMP  = 3'b010,
        OP_BR   = 3'b011,
        OP_CALL = 3'b100,
        OP_RET  = 3'b101,
        OP_RSV6 = 3'b110,
        OP_RSV7 = 3'b111
    } pc_op_e;

    // Absolute targets are unsigned addresses within the low part of the map.
    function automatic logic [ADDR_W-1:0] zext_addr(input logic [OFFS_W-1:0] v);
        return ADDR_W'(v);
    endfunction

    // Relative offsets are two's complement; the size cast of a signed
    // operand replicates the sign bit into the upper PC bits.
    function automatic logic signed [ADDR_W-1:0] sext_offs(input logic signed [OFFS_W-1:0] v);
        return ADDR_W'(v);
    endfunction

    // All PC arithmetic wraps modulo 2^ADDR_W; the carry out is discarded.
    function automatic logic [ADDR_W-1:0] wrap_add(input logic [ADDR_W-1:0] a,
                                                   input logic [ADDR_W-1:0] b);
        return a + b;
    endfunction

    // Architectural state
    logic [ADDR_W-1:0] pc_p1;
    logic [SP_W-1:0]   sp_p1;
    logic              err_p1;

    // Return-address storage is data, not control: it carries no reset and
    // its contents are meaningless until written by a push.
    logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];

    // Stage 0: decode and next-state computation from the current state
    pc_op_e                   op_p0;
    logic [ADDR_W-1:0]        pc_inc_p0;
    logic [ADDR_W-1:0]        pc_abs_p0;
    logic signed [ADDR_W-1:0] rel_off_p0;
    logic [ADDR_W-1:0]        pc_rel_p0;
    logic [PTR_W-1:0]         wr_idx_p0;
    logic [PTR_W-1:0]         rd_idx_p0;
    logic [ADDR_W-1:0]        top_p0;
    logic                     full_p0;
    logic                     empty_p0;

    logic [ADDR_W-1:0]        pc_nxt_p0;
    logic [SP_W-1:0]          sp_nxt_p0;
    logic                     push_p0;
    logic                     err_set_p0;

    assign op_p0      = pc_op_e'(pc_ctrl);
    assign pc_inc_p0  = wrap_add(pc_p1, ADDR_W'(1));
    assign pc_abs_p0  = zext_addr(offset_addr);
    assign rel_off_p0 = sext_offs(offset_addr);
    assign pc_rel_p0  = wrap_add(pc_p1, ADDR_W'(rel_off_p0));

    assign full_p0  = (sp_p1 == SP_FULL);
    assign empty_p0 = (sp_p1 == SP_EMPTY);

    // Push goes to entry [sp]; the top of stack is entry [sp-1]. With a
    // power-of-two depth the low PTR_W bits address the array directly.
    // rd_idx is garbage when the stack is empty but is never used then.
    assign wr_idx_p0 = PTR_W'(sp_p1);
    assign rd_idx_p0 = PTR_W'(sp_p1 - SP_W'(1));
    assign top_p0    = stack_mem[rd_idx_p0];

    always_comb begin
        pc_nxt_p0  = pc_p1;
        sp_nxt_p0  = sp_p1;
        push_p0    = 1'b0;
        err_set_p0 = 1'b0;

        if (en_pc) begin
            case (op_p0)
                OP_INC: begin
                    pc_nxt_p0 = pc_inc_p0;
                end
                OP_JMP: begin
                    pc_nxt_p0 = pc_abs_p0;
                end
                OP_BR: begin
                    pc_nxt_p0 = cond ? pc_rel_p0 : pc_inc_p0;
                end
                OP_CALL: begin
                    // The jump happens even when the return address cannot
                    // be saved; the lost push is flagged instead.
                    pc_nxt_p0 = pc_abs_p0;
                    if (full_p0) begin
                        err_set_p0 = 1'b1;
                    end else begin
                        push_p0   = 1'b1;
                        sp_nxt_p0 = sp_p1 + SP_W'(1);
                    end
                end
                OP_RET: begin
                    // Returning with nothing on the stack falls through to
                    // the next instruction rather than jumping to garbage.
                    if (empty_p0) begin
                        pc_nxt_p0  = pc_inc_p0;
                        err_set_p0 = 1'b1;
                    end else begin
                        pc_nxt_p0 = top_p0;
                        sp_nxt_p0 = sp_p1 - SP_W'(1);
                    end
                end
                default: begin
                    // hold and reserved encodings leave everything unchanged
                end
            endcase
        end
    end

    // Stage 1: state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_p1  <= RESET_VEC;
            sp_p1  <= SP_EMPTY;
            err_p1 <= 1'b0;
        end else begin
            pc_p1 <= pc_nxt_p0;
            sp_p1 <= sp_nxt_p0;
            // A new error outranks a clear arriving on the same edge.
            if (err_set_p0) begin
                err_p1 <= 1'b1;
            end else if (err_clr) begin
                err_p1 <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_p0) begin
            stack_mem[wr_idx_p0] <= pc_inc_p0;
        end
    end

    assign pc_out    = pc_p1;
    assign sp_level  = sp_p1;
    assign stk_full  = (sp_p1 == SP_FULL);
    assign stk_empty = (sp_p1 == SP_EMPTY);
    assign stk_err   = err_p1;

endmodule

// File: tb/tb_pc_stack_unit.sv
`timescale 1ns/1ps
module tb_pc_stack_unit;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        en_pc;
    logic [2:0]  pc_ctrl;
    logic [7:0]  offset_addr;
    logic        cond;
    logic        err_clr;
    logic [15:0] pc_out;
    logic [2:0]  sp_level;
    logic        stk_full;
    logic        stk_empty;
    logic        stk_err;

    pc_stack_unit #(
        .ADDR_W      (16),
        .OFFS_W      (8),
        .STACK_DEPTH (DEPTH),
        .RESET_VEC   (16'h0001)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en_pc       (en_pc),
        .pc_ctrl     (pc_ctrl),
        .offset_addr (offset_addr),
        .cond        (cond),
        .err_clr     (err_clr),
        .pc_out      (pc_out),
        .sp_level    (sp_level),
        .stk_full    (stk_full),
        .stk_empty   (stk_empty),
        .stk_err     (stk_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Apply one command, let one posedge take it, sample 1 ns later.
    task automatic step(input logic en, input logic [2:0] ctrl, input logic [7:0] off,
                        input logic c, input logic clr);
        en_pc       = en;
        pc_ctrl     = ctrl;
        offset_addr = off;
        cond        = c;
        err_clr     = clr;
        @(posedge clk);
        #1;
    endtask

    // Behavioural reference: PC as a number, stack as a queue.
    logic [15:0] m_pc;
    logic [15:0] m_stk[$];
    logic        m_err;

    task automatic model_reset();
        m_pc = 16'h0001;
        m_stk.delete();
        m_err = 1'b0;
    endtask

    task automatic model_step(input logic en, input logic [2:0] ctrl, input logic [7:0] off,
                              input logic c, input logic clr);
        logic set;
        set = 1'b0;
        if (en) begin
            case (ctrl)
                3'd1: m_pc = m_pc + 16'd1;
                3'd2: m_pc = {8'h00, off};
                3'd3: m_pc = c ? m_pc + {{8{off[7]}}, off} : m_pc + 16'd1;
                3'd4: begin
                    if (m_stk.size() == DEPTH) set = 1'b1;
                    else m_stk.push_back(m_pc + 16'd1);
                    m_pc = {8'h00, off};
                end
                3'd5: begin
                    if (m_stk.size() == 0) begin
                        m_pc = m_pc + 16'd1;
                        set  = 1'b1;
                    end else begin
                        m_pc = m_stk.pop_back();
                    end
                end
                default: ;
            endcase
        end
        if (set) m_err = 1'b1;
        else if (clr) m_err = 1'b0;
    endtask

    typedef struct {
        logic        en;
        logic [2:0]  ctrl;
        logic [7:0]  off;
        logic        c;
        logic        clr;
        logic [15:0] pc;
        logic [2:0]  sp;
        logic        err;
    } vec_t;

    vec_t vecs[64];
    int   nv = 0;

    task automatic add_vec(input logic en, input logic [2:0] ctrl, input logic [7:0] off,
                           input logic c, input logic clr, input logic [15:0] pc,
                           input logic [2:0] sp, input logic err);
        vecs[nv] = '{en, ctrl, off, c, clr, pc, sp, err};
        nv++;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        //       en ctrl  off    c  clr  pc        sp  err
        add_vec(1, 3'd1, 8'h00, 0, 0, 16'h0002, 0, 0); // INC
        add_vec(1, 3'd1, 8'h00, 0, 0, 16'h0003, 0, 0);
        add_vec(1, 3'd1, 8'h00, 0, 0, 16'h0004, 0, 0);
        add_vec(1, 3'd2, 8'h00, 0, 0, 16'h0000, 0, 0); // JMP 0
        add_vec(1, 3'd3, 8'hFF, 1, 0, 16'hFFFF, 0, 0); // BR -1 wraps down
        add_vec(1, 3'd1, 8'h00, 0, 0, 16'h0000, 0, 0); // INC wraps up
        add_vec(1, 3'd2, 8'h80, 0, 0, 16'h0080, 0, 0); // JMP zero-extends
        add_vec(1, 3'd3, 8'hFE, 1, 0, 16'h007E, 0, 0); // BR -2
        add_vec(1, 3'd3, 8'hFE, 0, 0, 16'h007F, 0, 0); // BR not taken
        add_vec(1, 3'd2, 8'h00, 0, 0, 16'h0000, 0, 0);
        add_vec(1, 3'd3, 8'hF0, 1, 0, 16'hFFF0, 0, 0);
        add_vec(1, 3'd3, 8'h7F, 1, 0, 16'h006F, 0, 0); // BR +127 wraps
        add_vec(1, 3'd2, 8'h10, 0, 0, 16'h0010, 0, 0);
        add_vec(1, 3'd4, 8'h20, 0, 0, 16'h0020, 1, 0); // nested calls
        add_vec(1, 3'd4, 8'h30, 0, 0, 16'h0030, 2, 0);
        add_vec(1, 3'd5, 8'h00, 0, 0, 16'h0021, 1, 0);
        add_vec(1, 3'd5, 8'h00, 0, 0, 16'h0011, 0, 0);
        add_vec(1, 3'd0, 8'h55, 1, 0, 16'h0011, 0, 0); // hold
        add_vec(1, 3'd6, 8'h55, 1, 0, 16'h0011, 0, 0); // reserved
        add_vec(1, 3'd7, 8'h55, 1, 0, 16'h0011, 0, 0); // reserved
        add_vec(1, 3'd4, 8'h40, 0, 0, 16'h0040, 1, 0); // fill stack
        add_vec(1, 3'd4, 8'h41, 0, 0, 16'h0041, 2, 0);
        add_vec(1, 3'd4, 8'h42, 0, 0, 16'h0042, 3, 0);
        add_vec(1, 3'd4, 8'h43, 0, 0, 16'h0043, 4, 0);
        add_vec(1, 3'd4, 8'h44, 0, 0, 16'h0044, 4, 1); // overflow
        add_vec(1, 3'd5, 8'h00, 0, 0, 16'h0043, 3, 1);
        add_vec(1, 3'd5, 8'h00, 0, 0, 16'h0042, 2, 1);
        add_vec(1, 3'd5, 8'h00, 0, 0, 16'h0041, 1, 1);
        add_vec(1, 3'd5, 8'h00, 0, 0, 16'h0012, 0, 1);
        add_vec(1, 3'd0, 8'h00, 0, 1, 16'h0012, 0, 0); // err_clr
        add_vec(1, 3'd5, 8'h00, 0, 0, 16'h0013, 0, 1); // underflow
        add_vec(0, 3'd4, 8'h50, 0, 0, 16'h0013, 0, 1); // disabled CALL
        add_vec(0, 3'd4, 8'h50, 0, 0, 16'h0013, 0, 1);
        add_vec(0, 3'd4, 8'h50, 0, 0, 16'h0013, 0, 1);
        add_vec(0, 3'd4, 8'h50, 0, 1, 16'h0013, 0, 0); // clear while disabled
        add_vec(1, 3'd5, 8'h00, 0, 1, 16'h0014, 0, 1); // set beats clear
        add_vec(1, 3'd0, 8'h00, 0, 1, 16'h0014, 0, 0);

        rst = 1'b0;
        en_pc = 1'b0;
        pc_ctrl = 3'd0;
        offset_addr = 8'h00;
        cond = 1'b0;
        err_clr = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_pc", 32'(pc_out), 32'h0001);
        check("rst_sp", 32'(sp_level), 32'd0);
        check("rst_empty", 32'(stk_empty), 32'd1);
        check("rst_full", 32'(stk_full), 32'd0);
        check("rst_err", 32'(stk_err), 32'd0);
        rst = 1'b1;

        for (int i = 0; i < nv; i++) begin
            step(vecs[i].en, vecs[i].ctrl, vecs[i].off, vecs[i].c, vecs[i].clr);
            check($sformatf("v%0d_pc", i), 32'(pc_out), 32'(vecs[i].pc));
            check($sformatf("v%0d_sp", i), 32'(sp_level), 32'(vecs[i].sp));
            check($sformatf("v%0d_err", i), 32'(stk_err), 32'(vecs[i].err));
            check($sformatf("v%0d_full", i), 32'(stk_full), 32'(vecs[i].sp == 3'd4));
            check($sformatf("v%0d_empty", i), 32'(stk_empty), 32'(vecs[i].sp == 3'd0));
        end

        // Async reset in the middle of a populated stack
        step(1, 3'd4, 8'h60, 0, 0);
        step(1, 3'd4, 8'h61, 0, 0);
        step(1, 3'd4, 8'h62, 0, 0);
        check("pre_arst_sp", 32'(sp_level), 32'd3);
        check("pre_arst_pc", 32'(pc_out), 32'h0062);
        #2 rst = 1'b0;
        #1;
        check("arst_pc", 32'(pc_out), 32'h0001);
        check("arst_sp", 32'(sp_level), 32'd0);
        check("arst_empty", 32'(stk_empty), 32'd1);
        #1 rst = 1'b1;
        model_reset();
        step(1, 3'd5, 8'h00, 0, 0);
        model_step(1, 3'd5, 8'h00, 0, 0);
        check("arst_ret_pc", 32'(pc_out), 32'h0002);
        check("arst_ret_err", 32'(stk_err), 32'd1);
        check("arst_ret_sp", 32'(sp_level), 32'd0);

        // Randomized traffic against the queue model
        for (int n = 0; n < 600; n++) begin
            logic       r_en;
            logic [2:0] r_ctrl;
            logic [7:0] r_off;
            logic       r_c;
            logic       r_clr;
            int         sel;
            r_en = ($urandom_range(0, 9) != 0);
            sel  = $urandom_range(0, 9);
            if (sel < 3)      r_ctrl = 3'd4;
            else if (sel < 6) r_ctrl = 3'd5;
            else              r_ctrl = 3'($urandom_range(0, 7));
            r_off = 8'($urandom);
            r_c   = 1'($urandom);
            r_clr = ($urandom_range(0, 7) == 0);
            step(r_en, r_ctrl, r_off, r_c, r_clr);
            model_step(r_en, r_ctrl, r_off, r_c, r_clr);
            check("rnd_pc", 32'(pc_out), 32'(m_pc));
            check("rnd_sp", 32'(sp_level), 32'(m_stk.size()));
            check("rnd_err", 32'(stk_err), 32'(m_err));
            check("rnd_full", 32'(stk_full), 32'(m_stk.size() == DEPTH));
            check("rnd_empty", 32'(stk_empty), 32'(m_stk.size() == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
